// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin two-master arbiter in front of the single-ported
//               dmem. Supports locked bursts and rejects out-of-range addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter logic [31:0] DMEM_TOP  = 32'h003F_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  // master 0 (CPU load/store path)
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_we,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  // master 1 (peripheral DMA port)
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_we,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  // dmem side
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_owner;      // master performing (or last performing) an access
  logic        r_last;       // most recent winner, for round-robin
  logic        r_locked;     // owner holds burst ownership
  logic [7:0]  r_burst_cnt;  // grants so far in the locked sequence
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_we;

  logic [1:0]  w_req;
  logic [1:0]  w_lock;
  logic        w_grant;
  logic        w_winner;
  logic        w_cont;       // grant continues an existing locked burst
  logic        w_lock_eff;   // lock still in force after the current access
  logic        w_oor;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_we;

  assign w_req  = {m1_req, m0_req};
  assign w_lock = {m1_lock, m0_lock};
  assign w_oor  = (r_addr > DMEM_TOP);

  assign w_sel_addr  = w_winner ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_winner ? m1_wdata : m0_wdata;
  assign w_sel_we    = w_winner ? m1_we    : m0_we;

  // A burst that has reached its limit is treated as released at the end of
  // its final access, so the waiting master can be granted back-to-back.
  assign w_lock_eff = r_locked && (r_burst_cnt != C_MAX_BURST);

  // Next-state and grant selection
  always_comb begin
    w_grant     = 1'b0;
    w_winner    = 1'b0;
    w_cont      = 1'b0;
    w_state_nxt = IDLE;
    case (r_state)
      IDLE: begin
        if (r_locked && w_req[r_owner] && w_lock[r_owner]) begin
          w_grant  = 1'b1;
          w_winner = r_owner;
          w_cont   = 1'b1;
        end else if (|w_req) begin
          w_grant  = 1'b1;
          w_winner = (&w_req) ? ~r_last : w_req[1];
        end
      end
      ACCESS: begin
        // the owner's own req here is the request just served; ignore it
        if (w_req[~r_owner] && !w_lock_eff) begin
          w_grant  = 1'b1;
          w_winner = ~r_owner;
        end
      end
      default: ;
    endcase
    if (w_grant) begin
      w_state_nxt = ACCESS;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload latch, ownership, round-robin pointer and burst tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_locked    <= 1'b0;
      r_burst_cnt <= 8'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_we        <= 4'd0;
    end else if (w_grant) begin
      r_owner  <= w_winner;
      r_last   <= w_winner;
      r_addr   <= w_sel_addr;
      r_wdata  <= w_sel_wdata;
      r_we     <= w_sel_we;
      r_locked <= w_lock[w_winner];
      if (w_cont) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end else begin
        r_burst_cnt <= w_lock[w_winner] ? 8'd1 : 8'd0;
      end
    end else if (r_state == IDLE) begin
      r_locked    <= 1'b0;
      r_burst_cnt <= 8'd0;
    end else begin
      r_locked    <= w_lock_eff;
      r_burst_cnt <= w_lock_eff ? r_burst_cnt : 8'd0;
    end
  end

  // Response registers: rvalid pulses the cycle after the access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= 32'd0;
      m1_rdata  <= 32'd0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (r_state == ACCESS) begin
        if (r_owner) begin
          m1_rvalid <= 1'b1;
          m1_err    <= w_oor;
          m1_rdata  <= w_oor ? 32'd0 : drdata;
        end else begin
          m0_rvalid <= 1'b1;
          m0_err    <= w_oor;
          m0_rdata  <= w_oor ? 32'd0 : drdata;
        end
      end
    end
  end

  // dmem drive and grants; derived from state so reset kills a write at once
  assign m0_gnt = (r_state == ACCESS) && !r_owner;
  assign m1_gnt = (r_state == ACCESS) &&  r_owner;
  assign daddr  = r_addr;
  assign dwdata = r_wdata;
  assign dwe    = ((r_state == ACCESS) && !w_oor) ? r_we : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a simple
//               byte-lane dmem model behind it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_lock, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_we;
  logic        m1_req, m1_lock, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_we;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dwe;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  logic [31:0] mem [0:1023];

  dmem_arbiter #(.MAX_BURST(8), .DMEM_TOP(32'h003F_FFFF)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
    .m1_rdata(m1_rdata),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: combinational read, byte-lane write on posedge
  assign drdata = mem[daddr[11:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (dwe[b]) mem[daddr[11:2]][8*b +: 8] <= dwdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete m0 transfer from IDLE; entered and left at posedge+1
  task automatic m0_xfer(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] we, input logic [3:0] exp_dwe,
                         input logic [31:0] exp_rdata, input logic exp_err);
    m0_addr = a; m0_wdata = d; m0_we = we; m0_req = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_gnt0"}, 32'(m0_gnt), 32'd1);
    chk({tag, "_dwe"},  32'(dwe), 32'(exp_dwe));
    chk({tag, "_daddr"}, daddr, a);
    m0_req = 1'b0; m0_we = 4'd0;
    @(posedge clk); #1;
    chk({tag, "_rvalid0"}, 32'(m0_rvalid), 32'd1);
    chk({tag, "_err0"},    32'(m0_err), 32'(exp_err));
    chk({tag, "_rdata0"},  m0_rdata, exp_rdata);
    chk({tag, "_dwe_after"}, 32'(dwe), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Directed sequence
  initial begin
    int m1cnt;
    int last_m1_cyc;
    logic seen0;

    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0]          = 32'h55AA55AA;
    mem[32'h104>>2] = 32'h0BADF00D;
    mem[32'h300>>2] = 32'h11223344;
    mem[32'h400>>2] = 32'hA5A5A5A5;

    reset = 1'b1;
    m0_req = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0;
    m1_req = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_rvalid_err", {28'd0, m1_rvalid, m0_rvalid, m1_err, m0_err}, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dwdata", dwdata, 32'd0);
    chk("rst_dwe", 32'(dwe), 32'd0);
    reset = 1'b0;

    // 1: full write then readback
    m0_xfer("t1w", 32'h100, 32'hDEADBEEF, 4'hF, 4'hF, 32'h0, 1'b0);
    m0_xfer("t1r", 32'h100, 32'h0, 4'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // 2: continuous contention from reset alternates m0,m1,... back-to-back
    pulse_reset();
    m0_addr = 32'h100; m0_we = 0; m1_addr = 32'h104; m1_we = 0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t2_gnt0_%0d", i), 32'(m0_gnt), 32'((i % 2) == 0));
      chk($sformatf("t2_gnt1_%0d", i), 32'(m1_gnt), 32'((i % 2) == 1));
      if (i > 0 && (i % 2) == 1) chk($sformatf("t2_rd0_%0d", i), m0_rdata, 32'hDEADBEEF);
      if (i > 0 && (i % 2) == 0) chk($sformatf("t2_rd1_%0d", i), m1_rdata, 32'h0BADF00D);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    chk("t2_rvalid1_last", 32'(m1_rvalid), 32'd1);
    @(posedge clk); #1;

    // 3: m1 locked burst of 10 reads against a persistent m0 request
    m1_addr = 32'h104; m1_lock = 1'b1; m1_req = 1'b1;
    @(posedge clk); #1;
    chk("t3_first_gnt1", 32'(m1_gnt), 32'd1);
    m1cnt = 1; last_m1_cyc = 0; seen0 = 1'b0;
    m0_addr = 32'h100; m0_req = 1'b1;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (m0_gnt && m1_gnt) chk("t3_both_gnt", 32'd1, 32'd0);
      if (m0_gnt && !seen0) begin
        chk("t3_m1_grants_before_m0", 32'(m1cnt), 32'd8);
        chk("t3_burst_spacing", 32'(last_m1_cyc), 32'd14);
        seen0 = 1'b1;
        m0_req = 1'b0;
      end
      if (m1_gnt) begin
        m1cnt++;
        if (!seen0) last_m1_cyc = cyc;
        if (m1cnt == 10) begin
          m1_req = 1'b0; m1_lock = 1'b0;
        end
      end
      if (m1cnt == 10 && seen0) break;
    end
    chk("t3_done", {30'd0, seen0, 1'b0} | 32'(m1cnt == 10), 32'd3);
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // 4: out-of-range write is suppressed and flagged
    m0_xfer("t4w", 32'h0040_0000, 32'hCAFEF00D, 4'hF, 4'h0, 32'h0, 1'b1);
    m0_xfer("t4r", 32'h0, 32'h0, 4'h0, 4'h0, 32'h55AA55AA, 1'b0);

    // 5: single byte-lane write merges into existing word
    m0_xfer("t5w", 32'h300, 32'h0000AB00, 4'b0010, 4'b0010, 32'h11223344, 1'b0);
    m0_xfer("t5r", 32'h300, 32'h0, 4'h0, 4'h0, 32'h1122AB44, 1'b0);

    // 6: reset in the middle of a write access
    m0_addr = 32'h400; m0_wdata = 32'h12345678; m0_we = 4'hF; m0_req = 1'b1;
    @(posedge clk); #1;
    chk("t6_dwe_before", 32'(dwe), 32'hF);
    #2 reset = 1'b1;
    #1;
    chk("t6_dwe_reset", 32'(dwe), 32'd0);
    chk("t6_gnt0_reset", 32'(m0_gnt), 32'd0);
    m0_req = 1'b0; m0_we = 4'd0;
    @(posedge clk); #1;
    chk("t6_no_rvalid", 32'(m0_rvalid), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t6_mem_word", mem[32'h400>>2], 32'hA5A5A5A5);
    m0_xfer("t6r", 32'h400, 32'h0, 4'h0, 4'h0, 32'hA5A5A5A5, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
